// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width: wide enough to hold 0..n.
  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbit_adder.sv
// N-bit ripple-carry adder.
module nbit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  // Bit-serial carry chain, LSB to MSB.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[N];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned NxN multiplier: one shared N-bit adder, N shift-and-add
// iterations, start/busy/done handshake toward the control unit.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = CNT_W(N);

  state_t state, next_state;

  logic [N-1:0]  m_reg;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  q_reg;
  logic          c_reg;
  logic [CW-1:0] cnt;

  logic [N-1:0]  sum;
  logic          carry;
  logic          c_pre;
  logic [N-1:0]  a_pre;
  logic [N-1:0]  a_nxt;
  logic [N-1:0]  q_nxt;
  logic          last_iter;

  nbit_adder #(.N(N)) u_adder (
    .a    (a_reg),
    .b    (m_reg),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  assign last_iter = (cnt == CW'(N - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  // Conditional add then right shift of {C,A,Q}, merged into one update.
  // c_reg is always zero between iterations, so it stands in for the 0 of the no-add path.
  always_comb begin
    c_pre = c_reg;
    a_pre = a_reg;
    if (q_reg[0]) begin
      c_pre = carry;
      a_pre = sum;
    end
    a_nxt = {c_pre, a_pre[N-1:1]};
    q_nxt = {a_pre[0], q_reg[N-1:1]};
  end

  // Next-state logic: DONE always returns to IDLE, start only matters in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_iter) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Datapath registers: operand capture, iteration, result load on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            a_reg <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          c_reg <= 1'b0;
          a_reg <= a_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt + CW'(1);
          if (last_iter) product <= {a_nxt, q_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at N=8 and N=4.
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start8, start4;
  logic [7:0]  a8, b8;
  logic [3:0]  a4, b4;
  logic        busy8, done8, busy4, done4;
  logic [15:0] product8;
  logic [7:0]  product4;

  int unsigned n_cmp;
  int unsigned n_err;

  shift_add_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8)
  );

  shift_add_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One complete multiply on the selected instance, with handshake checks.
  task automatic mul_op(input bit w4, input int unsigned x, input int unsigned y,
                        input int unsigned exp, input string tag);
    int unsigned nb;
    bit          seen;
    int unsigned n;
    n = w4 ? 4 : 8;
    @(negedge clk);
    if (w4) begin a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1; end
    else    begin a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    nb   = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (w4 ? done4 : done8) seen = 1'b1;
      else begin
        if (w4 ? busy4 : busy8) nb++;
        @(negedge clk);
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " busy_cycles"}, nb, n);
    chk({tag, " product"}, w4 ? 32'(product4) : 32'(product8), exp);
    @(negedge clk);
    chk({tag, " done_width"}, 32'(w4 ? done4 : done8), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nd, t1, t2;
    bit          hold_ok;

    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset busy8",    32'(busy8),    32'd0);
    chk("reset done8",    32'(done8),    32'd0);
    chk("reset product8", 32'(product8), 32'd0);
    chk("reset busy4",    32'(busy4),    32'd0);
    chk("reset product4", 32'(product4), 32'd0);

    mul_op(1'b0, 13,  11,  143,   "m13x11");
    mul_op(1'b0, 0,   200, 0,     "m0x200");
    mul_op(1'b0, 255, 255, 65025, "m255x255");

    // start re-pulsed during RUN and in the DONE cycle must be ignored
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    nd = 0;
    for (int i = 0; i < 25; i++) begin
      start8 = 1'b0;
      if (done8) begin
        nd++;
        if (nd == 1) begin
          chk("ign product_at_done", 32'(product8), 32'd63);
          a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        end
      end else if (busy8 && (i == 2 || i == 5)) begin
        a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("ign done_count", nd, 1);
    chk("ign product_final", 32'(product8), 32'd63);
    chk("ign idle", 32'(busy8), 32'd0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst pre_busy", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst busy",    32'(busy8),    32'd0);
    chk("rst done",    32'(done8),    32'd0);
    chk("rst product", 32'(product8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8 || busy8) nd++;
      @(negedge clk);
    end
    chk("rst no_activity", nd, 0);
    mul_op(1'b0, 100, 100, 10000, "m100x100");

    // back-to-back with start held high
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd6;
    nd = 0; t1 = 0; t2 = 0; hold_ok = 1'b1;
    for (int cyc = 0; cyc < 40 && nd < 2; cyc++) begin
      if (done8) begin
        nd++;
        if (nd == 1) begin
          chk("b2b first", 32'(product8), 32'd6);
          t1 = cyc;
        end else begin
          chk("b2b second", 32'(product8), 32'd30);
          t2 = cyc;
          start8 = 1'b0;
        end
      end else if (busy8 && nd == 1 && product8 != 16'd6) begin
        hold_ok = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("b2b done_count", nd, 2);
    chk("b2b spacing", t2 - t1, 10);
    chk("b2b hold", 32'(hold_ok), 32'd1);

    // N=4 instance
    mul_op(1'b1, 15, 15, 225, "n4 m15x15");
    for (int k = 0; k < 1000; k++) begin
      int unsigned x, y;
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      mul_op(1'b1, x, y, x * y, $sformatf("n4 rnd%0d %0dx%0d", k, x, y));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned N×N multiplier controller. It time-shares a single N-bit ripple adder (`nbit_adder`, cin tied 0) over N iterations of a shift-and-add loop. The block sits beside the ALU as its multi-cycle multiply unit and exposes a start/busy/done handshake to the control unit.

## Interface
Parameters:
- `N`, default 8: operand width (N ≥ 2); product width is 2N.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  N  multiplicand, unsigned; captured on the accepting edge.
- `b`  in  N  multiplier, unsigned; captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; product valid.
- `product`  out  2N  result register; holds until the next completion.

## Operation
- Internal registers:
  - M (N bits): multiplicand.
  - A (N bits): accumulator high half.
  - Q (N bits): multiplier, which becomes the product low half.
  - C (1 bit): adder carry.
  - cnt: $clog2(N+1) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - With start=1 at an edge: M←a, Q←b, A←0, C←0, cnt←0, go to RUN.
  - With start=0: stay in IDLE.
- RUN, on each edge:
  - If Q[0]=1, {C,A}←A+M via the adder (sum plus cout). Otherwise {C,A}←{0,A}.
  - Then {C,A,Q}←{0,C,A,Q} >> 1. This is done as one combined update in the same edge.
  - cnt←cnt+1. When cnt==N-1, go to DONE and load product←{A',Q'} (the post-shift values).
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start is ignored in DONE.
- start while busy or in DONE is ignored and has no side effects; the requester must hold or re-assert start in IDLE.
- Arithmetic is unsigned and exact. No overflow is possible: (2^N−1)² < 2^2N. The adder carry is never discarded before the shift.
- `product` changes only on entry to DONE or on reset. It stays stable during a subsequent RUN.
- Reset (any state, including mid-RUN):
  - state←IDLE; busy=0, done=0, product=0.
  - A, Q, M, C, cnt←0.
  - The aborted operation produces no done pulse.

## Timing
- Accepting edge = edge k (IDLE, start=1).
- busy is high in the cycles following edges k … k+N−1, i.e. N cycles.
- done is high in the single cycle following edge k+N; product is valid in that cycle.
- Latency is N+1 edges from acceptance to return to IDLE. The earliest next acceptance is edge k+N+2, giving a throughput of one multiply per N+2 cycles.
- busy and done are registered (Moore) outputs and are never high together.
- The combinational path per cycle is one N-bit ripple add plus the shift mux.

## Structure
- Shared package `mult_pkg`:
  - State enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Counter width function CNT_W(N) = $clog2(N+1).
- Sub-module: one instance of the existing `nbit_adder #(.N(N))` with a=A, b=M, cin=0, s→sum, cout→carry. No second adder.
- The remainder is a single FSM plus datapath registers in this module.

## Test plan
- N=8, a=0, b=200, start pulse → after N cycles done=1 for 1 cycle, product=0x0000; busy high exactly 8 cycles.
- N=8, a=13, b=11 → product=143 (0x008F). Then a=255, b=255 → product=65025 (0xFE01), with the final carry propagated correctly.
- N=8, a=7, b=9, then start re-pulsed with a=3, b=3 during RUN and again in the DONE cycle → ignored; product=63 and a single done pulse.
- N=8, a=100, b=100, rst asserted asynchronously at RUN iteration 4 → busy, done and product go to 0 immediately. No done pulse follows. A new start after reset yields a correct 10000 (0x2710).
- Back-to-back: start held high continuously with a=2,b=3 then a=5,b=6 → products 6 then 30, with done pulses N+2 cycles apart. product holds 6 throughout the second RUN.
- N=4 build: a=15, b=15 → product=225 (0xE1) after 4 busy cycles. Random unsigned pairs against a reference multiply, 1000 iterations.
